// File: rtl/axi_aw_router.sv
// rtl/axi_aw_router.sv - AXI write-address crossbar with per-slave round-robin arbitration and W-order FIFOs
module axi_aw_router #(
    parameter int                  NUM_M    = 2,
    parameter int                  NUM_S    = 6,
    parameter int                  ID_W     = 4,
    parameter int                  MIDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1,
    parameter int                  DEF_SLV  = NUM_S - 1,
    parameter logic [NUM_S*32-1:0] SLV_BASE = {NUM_S{32'h0}},
    parameter logic [NUM_S*32-1:0] SLV_MASK = {NUM_S{32'h0}},
    parameter int                  WORD_DEP = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_M*ID_W-1:0]           AWID_M,
    input  logic [NUM_M*32-1:0]             AWADDR_M,
    input  logic [NUM_M*4-1:0]              AWLEN_M,
    input  logic [NUM_M*3-1:0]              AWSIZE_M,
    input  logic [NUM_M*2-1:0]              AWBURST_M,
    input  logic [NUM_M-1:0]                AWVALID_M,
    output logic [NUM_M-1:0]                AWREADY_M,
    output logic [NUM_S*(MIDX_W+ID_W)-1:0]  AWID_S,
    output logic [NUM_S*32-1:0]             AWADDR_S,
    output logic [NUM_S*4-1:0]              AWLEN_S,
    output logic [NUM_S*3-1:0]              AWSIZE_S,
    output logic [NUM_S*2-1:0]              AWBURST_S,
    output logic [NUM_S-1:0]                AWVALID_S,
    input  logic [NUM_S-1:0]                AWREADY_S,
    output logic [NUM_S*MIDX_W-1:0]         WORD_MIDX_S,
    output logic [NUM_S-1:0]                WORD_VLD_S,
    input  logic [NUM_S-1:0]                WORD_POP_S
);

    localparam int SID_W = MIDX_W + ID_W;
    localparam int PTR_W = $clog2(WORD_DEP);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_M-1:0]        slv_req [NUM_S];
    logic [NUM_S-1:0]        gnt_vld;
    logic [NUM_S*MIDX_W-1:0] gnt_idx;

    // Each master raises a request toward exactly one slave: the lowest matching region, else the default slave.
    always_comb begin
        logic found;
        found = 1'b0;
        for (int s = 0; s < NUM_S; s++) begin
            slv_req[s] = '0;
        end
        for (int m = 0; m < NUM_M; m++) begin
            found = 1'b0;
            for (int s = 0; s < NUM_S; s++) begin
                if (!found && ((AWADDR_M[m*32 +: 32] & SLV_MASK[s*32 +: 32]) == SLV_BASE[s*32 +: 32])) begin
                    slv_req[s][m] = AWVALID_M[m];
                    found         = 1'b1;
                end
            end
            if (!found) begin
                slv_req[DEF_SLV][m] = AWVALID_M[m];
            end
        end
    end

    always_comb begin
        AWREADY_M = '0;
        for (int s = 0; s < NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (gnt_vld[s] && (gnt_idx[s*MIDX_W +: MIDX_W] == MIDX_W'(m))) begin
                    AWREADY_M[m] = 1'b1;
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_slv
        logic [MIDX_W-1:0] rr_ptr;
        logic              vld_q;
        logic [SID_W-1:0]  id_q;
        logic [31:0]       addr_q;
        logic [3:0]        len_q;
        logic [2:0]        size_q;
        logic [1:0]        burst_q;
        logic [MIDX_W-1:0] mem [WORD_DEP];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;
        logic              slot_ok;
        logic              gnt;
        logic              pop;
        logic [MIDX_W-1:0] sel;

        // A full FIFO blocks the grant even when a pop lands in the same cycle.
        assign slot_ok = !ARESET && (!vld_q || AWREADY_S[s]) && (cnt != CNT_W'(WORD_DEP));
        assign pop     = WORD_POP_S[s] && (cnt != '0);

        // First pass covers masters at or after the pointer, second pass wraps to the lowest index.
        always_comb begin
            gnt = 1'b0;
            sel = '0;
            for (int m = 0; m < NUM_M; m++) begin
                if (slot_ok && !gnt && slv_req[s][m] && (MIDX_W'(m) >= rr_ptr)) begin
                    gnt = 1'b1;
                    sel = MIDX_W'(m);
                end
            end
            for (int m = 0; m < NUM_M; m++) begin
                if (slot_ok && !gnt && slv_req[s][m]) begin
                    gnt = 1'b1;
                    sel = MIDX_W'(m);
                end
            end
        end

        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                vld_q   <= 1'b0;
                id_q    <= '0;
                addr_q  <= '0;
                len_q   <= '0;
                size_q  <= '0;
                burst_q <= '0;
                rr_ptr  <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
            end else begin
                if (gnt) begin
                    vld_q <= 1'b1;
                    for (int m = 0; m < NUM_M; m++) begin
                        if (sel == MIDX_W'(m)) begin
                            id_q    <= {sel, AWID_M[m*ID_W +: ID_W]};
                            addr_q  <= AWADDR_M[m*32 +: 32];
                            len_q   <= AWLEN_M[m*4 +: 4];
                            size_q  <= AWSIZE_M[m*3 +: 3];
                            burst_q <= AWBURST_M[m*2 +: 2];
                        end
                    end
                    rr_ptr <= (sel == MIDX_W'(NUM_M - 1)) ? '0 : sel + 1'b1;
                    wr_ptr <= wr_ptr + 1'b1;
                end else if (AWREADY_S[s]) begin
                    vld_q <= 1'b0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({gnt, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge ACLK) begin
            if (gnt) begin
                mem[wr_ptr] <= sel;
            end
        end

        assign gnt_vld[s]                      = gnt;
        assign gnt_idx[s*MIDX_W +: MIDX_W]     = sel;
        assign AWVALID_S[s]                    = vld_q;
        assign AWID_S[s*SID_W +: SID_W]        = id_q;
        assign AWADDR_S[s*32 +: 32]            = addr_q;
        assign AWLEN_S[s*4 +: 4]               = len_q;
        assign AWSIZE_S[s*3 +: 3]              = size_q;
        assign AWBURST_S[s*2 +: 2]             = burst_q;
        assign WORD_MIDX_S[s*MIDX_W +: MIDX_W] = mem[rd_ptr];
        assign WORD_VLD_S[s]                   = (cnt != '0);
    end

endmodule
